conv_coeff_sched: RTL and testbench
===================================

# conv_coeff_sched

Coefficient scheduler for the 3x3 `convolution` datapath. It holds two banks of nine 9-bit signed kernel coefficients: a host-writable shadow bank and an active bank. On each frame start it swaps the banks if a commit is pending, then streams the active bank into `convolution`'s `coeff_i` in lockstep with a one-cycle-delayed copy of the video syncs. It sits between the host register interface and `convolution`, and its `dv_o`/`hs_o`/`vs_o` drive the convolution's sync inputs directly.

## Interface
Parameters:
- `COEFF_W`, 9: coefficient width, two's complement.
- `KERNEL_N`, 9: coefficients per kernel (`M_WIDTH*M_DEPTH`).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `wr_en_i` in 1: host write strobe to the shadow bank.
- `wr_addr_i` in 4: coefficient index; only 0..8 are valid.
- `wr_data_i` in `COEFF_W`: coefficient value.
- `wr_ready_o` out 1: high when no commit is pending; writes are accepted only while high.
- `wr_drop_o` out 1: one-cycle pulse when a write is rejected.
- `commit_i` in 1: request a shadow→active swap at the next frame start.
- `commit_ack_o` out 1: one-cycle pulse when the swap happens.
- `dv_i`, `hs_i`, `vs_i` in 1 each: video syncs from the pixel source.
- `dv_o`, `hs_o`, `vs_o` out 1 each: syncs delayed by 1 cycle, to `convolution`.
- `coeff_o` out `COEFF_W`: coefficient stream, to `convolution.coeff_i`.
- `load_done_o` out 1: pulse on the cycle the last coefficient (index 8) is presented.
- `load_abort_o` out 1: pulse when `vs_i` falls before the load completes.

## Operation
- **Reset values.** All outputs are 0 except `wr_ready_o`, which is 1. Both banks reset to the identity kernel: index 4 = 1, all others 0. The pending flag clears and the FSM goes to IDLE.
- **Write rules.**
  - A write with `wr_en_i` high, `wr_ready_o` high and `wr_addr_i` ≤ 8 updates `shadow[wr_addr_i]` at the clock edge.
  - A write with `wr_ready_o` low, or with `wr_addr_i` ≥ 9, is dropped and pulses `wr_drop_o` on the next cycle.
- **Commit rules.**
  - `commit_i` sets the pending flag, and `wr_ready_o` goes low the next cycle.
  - `commit_i` while already pending has no effect.
  - A write and a commit in the same cycle: the write lands, then the flag sets.
- **Frame start** is the cycle T where `vs_i`=1 and the registered `vs_i`=0.
  - If pending is set, or `commit_i` is high at T, the banks swap at edge T. The old shadow becomes active; the new shadow is loaded with a copy of the new active contents.
  - On a swap, pending clears and `commit_ack_o` pulses at T+1.
- **FSM.**
  - IDLE: `coeff_o`=0. Frame start → LOAD with index k=0.
  - LOAD: `coeff_o`=`active[k]`; k increments each cycle. Goes to HOLD after k=8.
  - HOLD: `coeff_o`=0 until `vs_i` falls, then IDLE.
  - In LOAD, if `vs_i` falls: go to IDLE, pulse `load_abort_o`, `coeff_o`=0. The active bank is unchanged.
- **Width rule.** Coefficients pass through unmodified; no arithmetic is applied.

## Timing
- `vs_o`, `hs_o`, `dv_o` are `vs_i`, `hs_i`, `dv_i` registered once; latency is 1 cycle.
- With frame start at T:
  - `coeff_o`=`active[k]` at cycle T+1+k, for k=0..8.
  - `vs_o` is first high at T+1, aligned with index 0, which matches `convolution`'s address counter starting at 0 on its first `vs` cycle.
  - `load_done_o` pulses at T+9.
  - From T+10 on, `coeff_o`=0 (covers the convolution's writes at addr 9/10).
- `vs_i` low at cycle F while in LOAD: `load_abort_o` pulses at F+1.
- `wr_ready_o` returns high at T+1 after a swap.
- `rst` mid-load: the next cycle has `coeff_o`=0, the FSM is in IDLE, and banks are back to identity.

## Structure
- Package `conv_pkg` holds:
  - `COEFF_W`, `KERNEL_N`;
  - `coeff_t` (logic signed [COEFF_W-1:0]);
  - `kernel_t` (`coeff_t` [KERNEL_N]);
  - `IDENTITY_KERNEL` constant;
  - the FSM enum `sched_state_e` {IDLE, LOAD, HOLD}.
- Sub-module `conv_coeff_bank`: two-bank register file with write port, swap strobe and combinational active-bank read by index.
- The top level holds the FSM, index counter, pending flag and sync delay registers.

## Test plan
- **Reset default.** Reset, then a `vs_i` rise at T → `coeff_o` sequence 0,0,0,0,1,0,0,0,0 at T+1..T+9; `load_done_o` at T+9; `coeff_o`=0 at T+10.
- **Write and commit.** Write shadow[k]=k−4 (signed, 9'h1FC..9'h004), then `commit_i`, then a frame → `commit_ack_o` at T+1; stream −4..4; `wr_ready_o` low between commit and T+1.
- **Write while pending.** `wr_en_i` while pending, addr 2, data 7 → `wr_drop_o` pulse; the next frame streams the committed value, not 7. Also: addr 12 → dropped.
- **Commit on frame start.** `commit_i` on the same cycle as the `vs_i` rise → swap applies to this frame, ack at T+1.
- **Short vs pulse.** `vs_i` high for only 4 cycles → indices 0..3 streamed, `load_abort_o` pulse, no `load_done_o`; the next full frame streams the same active bank.
- **Reset mid-load.** Assert `rst` at T+5 → `coeff_o`=0 at T+6; the next frame streams the identity kernel.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution coefficient scheduler.
// The kernel is nine signed coefficients; both banks power up as the identity kernel.
package conv_pkg;

    localparam int COEFF_W  = 9;
    localparam int KERNEL_N = 9;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef coeff_t kernel_t [KERNEL_N];

    localparam kernel_t IDENTITY_KERNEL = '{4: coeff_t'(1), default: coeff_t'(0)};

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } sched_state_e;

endpackage

// File: rtl/conv_coeff_bank.sv
// Two-bank coefficient register file: host-written shadow bank and streamed active bank.
// A swap publishes the shadow (including any same-cycle write) into both banks.
module conv_coeff_bank
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [3:0]         wr_addr,
    input  logic [COEFF_W-1:0] wr_data,
    input  logic               swap,
    input  logic [3:0]         rd_idx,
    output logic [COEFF_W-1:0] rd_data
);

    kernel_t shadow;
    kernel_t active;
    kernel_t shadow_nxt;

    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < KERNEL_N; i++) begin
            if (wr_en && (wr_addr == 4'(i))) begin
                shadow_nxt[i] = wr_data;
            end
        end
    end

    // After a swap both banks hold the same kernel, so the shadow starts from the live coefficients.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= IDENTITY_KERNEL;
            active <= IDENTITY_KERNEL;
        end else begin
            shadow <= shadow_nxt;
            if (swap) begin
                active <= shadow_nxt;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < KERNEL_N; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_data = active[i];
            end
        end
    end

endmodule

// File: rtl/conv_coeff_sched.sv
// Coefficient scheduler: swaps banks on frame start when a commit is pending and
// streams the active kernel to the convolution in lockstep with the delayed syncs.
module conv_coeff_sched #(
    parameter int COEFF_W  = 9,
    parameter int KERNEL_N = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [3:0]         wr_addr_i,
    input  logic [COEFF_W-1:0] wr_data_i,
    output logic               wr_ready_o,
    output logic               wr_drop_o,
    input  logic               commit_i,
    output logic               commit_ack_o,
    input  logic               dv_i,
    input  logic               hs_i,
    input  logic               vs_i,
    output logic               dv_o,
    output logic               hs_o,
    output logic               vs_o,
    output logic [COEFF_W-1:0] coeff_o,
    output logic               load_done_o,
    output logic               load_abort_o
);
    import conv_pkg::*;

    sched_state_e state;
    sched_state_e state_nxt;

    logic               vs_q;
    logic               hs_q;
    logic               dv_q;
    logic               pending;
    logic               drop_q;
    logic               ack_q;
    logic               abort_q;
    logic [3:0]         idx;
    logic               frame_start;
    logic               swap;
    logic               wr_ok;
    logic               wr_bad;
    logic               last_idx;
    logic [COEFF_W-1:0] rd_data;

    assign frame_start = vs_i & ~vs_q;
    assign swap        = frame_start & (pending | commit_i);
    assign wr_ok       = wr_en_i & ~pending & (wr_addr_i < 4'(KERNEL_N));
    assign wr_bad      = wr_en_i & ~wr_ok;
    assign last_idx    = (idx == 4'(KERNEL_N - 1));

    conv_coeff_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .swap    (swap),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

    // A commit arriving on the frame-start cycle swaps immediately and never sets the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            dv_q    <= 1'b0;
            pending <= 1'b0;
            drop_q  <= 1'b0;
            ack_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            vs_q    <= vs_i;
            hs_q    <= hs_i;
            dv_q    <= dv_i;
            drop_q  <= wr_bad;
            ack_q   <= swap;
            abort_q <= (state == LOAD) && !vs_i && !last_idx;
            if (swap) begin
                pending <= 1'b0;
            end else if (commit_i) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= (state == LOAD) ? idx + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frame_start) state_nxt = LOAD;
            LOAD: begin
                if (!vs_i) begin
                    state_nxt = IDLE;
                end else if (last_idx) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: if (!vs_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        coeff_o     = '0;
        load_done_o = 1'b0;
        if (state == LOAD) begin
            coeff_o     = rd_data;
            load_done_o = last_idx;
        end
    end

    assign wr_ready_o   = ~pending;
    assign wr_drop_o    = drop_q;
    assign commit_ack_o = ack_q;
    assign load_abort_o = abort_q;
    assign vs_o         = vs_q;
    assign hs_o         = hs_q;
    assign dv_o         = dv_q;

endmodule

// File: tb/tb_conv_coeff_sched.sv
// Scoreboard bench for conv_coeff_sched: stimulus queues expected coefficient beats and
// pulses, a negedge monitor pops and compares them whenever the DUT presents them.
module tb_conv_coeff_sched;

    typedef logic signed [8:0] kern_t [9];
    typedef struct {
        logic [8:0] coeff;
        logic       done;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en_i = 1'b0;
    logic [3:0] wr_addr_i = '0;
    logic [8:0] wr_data_i = '0;
    logic       commit_i = 1'b0;
    logic       dv_i = 1'b0;
    logic       hs_i = 1'b0;
    logic       vs_i = 1'b0;
    logic       wr_ready_o;
    logic       wr_drop_o;
    logic       commit_ack_o;
    logic       dv_o;
    logic       hs_o;
    logic       vs_o;
    logic [8:0] coeff_o;
    logic       load_done_o;
    logic       load_abort_o;

    int checks = 0;
    int failures = 0;

    beat_t      beat_q[$];
    logic [2:0] pulse_q[$];

    kern_t ident_k = '{9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd1, 9'sd0, 9'sd0, 9'sd0, 9'sd0};
    kern_t ramp_k  = '{-9'sd4, -9'sd3, -9'sd2, -9'sd1, 9'sd0, 9'sd1, 9'sd2, 9'sd3, 9'sd4};
    kern_t b_k     = '{-9'sd4, -9'sd3, 9'sd5, -9'sd1, 9'sd0, 9'sd1, 9'sd2, 9'sd3, 9'sd4};
    kern_t c_k     = '{9'sd100, -9'sd3, 9'sd5, -9'sd1, 9'sd0, 9'sd1, 9'sd2, 9'sd3, -9'sd100};

    conv_coeff_sched #(.COEFF_W(9), .KERNEL_N(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_ready_o   (wr_ready_o),
        .wr_drop_o    (wr_drop_o),
        .commit_i     (commit_i),
        .commit_ack_o (commit_ack_o),
        .dv_i         (dv_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .dv_o         (dv_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .coeff_o      (coeff_o),
        .load_done_o  (load_done_o),
        .load_abort_o (load_abort_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one clock cycle of inputs and returns just after the closing edge.
    task automatic applyStimulus(input logic vs, input logic commit, input logic wen,
                                 input logic [3:0] addr, input logic [8:0] data);
        vs_i      = vs;
        commit_i  = commit;
        wr_en_i   = wen;
        wr_addr_i = addr;
        wr_data_i = data;
        @(posedge clk);
        #1;
        vs_i     = 1'b0;
        commit_i = 1'b0;
        wr_en_i  = 1'b0;
    endtask

    task automatic writeCoeff(input logic [3:0] addr, input logic [8:0] data, input bit exp_drop);
        if (exp_drop) pulse_q.push_back(3'b010);
        applyStimulus(1'b0, 1'b0, 1'b1, addr, data);
    endtask

    task automatic pushBeats(input int n, input kern_t k);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.coeff = (i < 9) ? k[i] : 9'd0;
            b.done  = (i == 8);
            beat_q.push_back(b);
        end
    endtask

    task automatic runFrame(input int high, input kern_t k, input bit commit_now, input bit exp_ack);
        if (exp_ack) pulse_q.push_back(3'b100);
        if (high < 9) pulse_q.push_back(3'b001);
        pushBeats(high, k);
        applyStimulus(1'b1, commit_now, 1'b0, 4'd0, 9'd0);
        if (exp_ack) checkOutput("wr_ready_after_swap", 16'(wr_ready_o), 16'd1);
        for (int c = 1; c < high; c++) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 9'd0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
    endtask

    // Monitor: every vs_o-high cycle is one coefficient beat; every pulse is one event.
    always @(negedge clk) begin
        if (!rst) begin
            if (vs_o) begin
                if (beat_q.size() == 0) begin
                    checkOutput("unexpected_beat", 16'(coeff_o), 16'h0dea);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    checkOutput("coeff", 16'(coeff_o), 16'(b.coeff));
                    checkOutput("load_done", 16'(load_done_o), 16'(b.done));
                end
            end else begin
                checkOutput("idle_coeff_zero", 16'({coeff_o, load_done_o}), 16'd0);
            end
            if (commit_ack_o || wr_drop_o || load_abort_o) begin
                if (pulse_q.size() == 0) begin
                    checkOutput("unexpected_pulse", 16'({commit_ack_o, wr_drop_o, load_abort_o}), 16'd0);
                end else begin
                    checkOutput("pulse ack/drop/abort", 16'({commit_ack_o, wr_drop_o, load_abort_o}),
                                16'(pulse_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset defaults
        rst = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
        checkOutput("reset_wr_ready", 16'(wr_ready_o), 16'd1);
        checkOutput("reset_coeff", 16'(coeff_o), 16'd0);
        checkOutput("reset_pulses", 16'({wr_drop_o, commit_ack_o, load_done_o, load_abort_o}), 16'd0);
        checkOutput("reset_syncs", 16'({vs_o, hs_o, dv_o}), 16'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);

        // Sync delay
        hs_i = 1'b1; dv_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
        checkOutput("sync_hs_dv_a", 16'({hs_o, dv_o}), 16'b10);
        hs_i = 1'b0; dv_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
        checkOutput("sync_hs_dv_b", 16'({hs_o, dv_o}), 16'b01);
        dv_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);

        // Identity kernel after reset
        runFrame(12, ident_k, 1'b0, 1'b0);

        // Write ramp then commit
        for (int i = 0; i < 9; i++) writeCoeff(4'(i), 9'(i - 4), 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 9'd0);
        checkOutput("wr_ready_pending", 16'(wr_ready_o), 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
        checkOutput("wr_ready_still_pending", 16'(wr_ready_o), 16'd0);
        runFrame(12, ramp_k, 1'b0, 1'b1);

        // Write while pending is dropped; double commit is a single commit
        writeCoeff(4'd2, 9'd5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 9'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 9'd0);
        checkOutput("wr_ready_double_commit", 16'(wr_ready_o), 16'd0);
        writeCoeff(4'd2, 9'd7, 1'b1);
        runFrame(12, b_k, 1'b0, 1'b1);
        writeCoeff(4'd12, 9'h055, 1'b1);
        runFrame(12, b_k, 1'b0, 1'b0);

        // Commit on the frame-start cycle
        writeCoeff(4'd0, 9'd100, 1'b0);
        writeCoeff(4'd8, 9'h19c, 1'b0);
        runFrame(12, c_k, 1'b1, 1'b1);

        // Short vs pulse aborts, active bank unchanged
        runFrame(4, c_k, 1'b0, 1'b0);
        runFrame(12, c_k, 1'b0, 1'b0);

        // Reset in the middle of a load
        pushBeats(4, c_k);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 9'd0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
        checkOutput("midload_rst_coeff", 16'(coeff_o), 16'd0);
        checkOutput("midload_rst_pulses", 16'({load_done_o, load_abort_o, commit_ack_o}), 16'd0);
        rst = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
        runFrame(12, ident_k, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, 9'd0);
        runFrame(12, ident_k, 1'b0, 1'b1);

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 9'd0);
        checkOutput("beat_queue_drained", 16'(beat_q.size()), 16'd0);
        checkOutput("pulse_queue_drained", 16'(pulse_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
